// File: rtl/scie_pkg.sv
// Shared decode constants, operation encoding and pipeline-stage record for the
// SCIE multiply-accumulate coprocessor.
package scie_pkg;

  localparam logic [6:0] SCIE_OPCODE    = 7'h0B;
  localparam int         SCIE_MAX_XLEN  = 64;
  localparam int         SCIE_MAX_IDX_W = 4;

  typedef enum logic [2:0] {
    OP_MAC   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_READ  = 3'd2,
    OP_CLEAR = 3'd3
  } scie_op_e;

  // Sized for the widest legal configuration; modules use the low bits they need.
  typedef struct packed {
    logic                      valid;
    scie_op_e                  op;
    logic [SCIE_MAX_IDX_W-1:0] index;
    logic [SCIE_MAX_XLEN-1:0]  rs1;
    logic [SCIE_MAX_XLEN-1:0]  rs2;
    logic                      illegal;
  } scie_stage_t;

  function automatic logic scie_is_illegal(input logic [31:0] insn);
    return (insn[6:0] != SCIE_OPCODE) || (insn[14:12] > 3'd3);
  endfunction

endpackage

// File: rtl/scie_mac_unit.sv
// Accumulator update datapath: MAC / LOAD / READ / CLEAR on one accumulator.
// Build option SCIE_MAC_SATURATE_EN clamps the MAC sum instead of wrapping.
module scie_mac_unit
  import scie_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  scie_op_e          op,
  input  logic [XLEN-1:0]   acc_in,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   acc_out
);

`ifdef SCIE_MAC_SATURATE_EN
  localparam int PW = 2 * XLEN;
  localparam int SW = PW + 1;

  logic signed [XLEN-1:0] acc_s;
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic signed [PW-1:0]   prod_full;
  logic signed [SW-1:0]   sum_full;
  logic        [XLEN-1:0] mac_res;

  // In range exactly when every bit above the result's sign bit matches it.
  function automatic logic [XLEN-1:0] sat_clamp(input logic signed [SW-1:0] s);
    if ((&s[SW-1:XLEN-1]) || !(|s[SW-1:XLEN-1]))
      return s[XLEN-1:0];
    else if (s[SW-1])
      return {1'b1, {(XLEN-1){1'b0}}};
    else
      return {1'b0, {(XLEN-1){1'b1}}};
  endfunction

  assign acc_s     = signed'(acc_in);
  assign rs1_s     = signed'(rs1);
  assign rs2_s     = signed'(rs2);
  assign prod_full = PW'(rs1_s) * PW'(rs2_s);
  assign sum_full  = SW'(acc_s) + SW'(prod_full);
  assign mac_res   = sat_clamp(sum_full);
`else
  logic [XLEN-1:0] mac_res;

  // Low XLEN bits of a signed product equal those of the unsigned product.
  function automatic logic [XLEN-1:0] wrap_mac(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    logic [XLEN-1:0] p;
    p = x * y;
    return a + p;
  endfunction

  assign mac_res = wrap_mac(acc_in, rs1, rs2);
`endif

  always_comb begin
    acc_out = acc_in;
    case (op)
      OP_MAC:   acc_out = mac_res;
      OP_LOAD:  acc_out = rs1;
      OP_READ:  acc_out = acc_in;
      OP_CLEAR: acc_out = '0;
      default:  acc_out = acc_in;
    endcase
  end

endmodule

// File: rtl/scie_mac_pipe.sv
// SCIE custom-0 MAC coprocessor: fixed-latency pipeline with a per-accumulator
// hazard scoreboard. Build option SCIE_MAC_SATURATE_EN selects saturating MAC.
module scie_mac_pipe
  import scie_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NACC    = 4,
  parameter int LATENCY = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  output logic            io_ready,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd,
  output logic            io_rd_valid,
  output logic            io_illegal
);

  localparam int IDX_W = (NACC > 1) ? $clog2(NACC) : 1;

  scie_stage_t     stage_q [LATENCY];
  scie_stage_t     stage_d [LATENCY];
  logic [XLEN-1:0] acc_q   [NACC];
  logic [XLEN-1:0] acc_d   [NACC];
  logic [XLEN-1:0] rd_q, rd_d;
  logic            rd_valid_q, rd_valid_d;
  logic            illegal_q, illegal_d;

  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] fin_idx;
  logic             hazard;
  logic             accept;
  logic             cur_illegal;
  logic [XLEN-1:0]  mac_out;
  logic             unused_insn_bits;

  assign unused_insn_bits = ^{io_insn[31:25], io_insn[24:15], io_insn[11:7]};

  generate
    if (NACC > 1) begin : g_idx
      assign cur_idx = io_insn[25 +: IDX_W];
    end else begin : g_idx1
      assign cur_idx = '0;
    end
  endgenerate

  assign cur_illegal = scie_is_illegal(io_insn);
  assign fin_idx     = stage_q[LATENCY-1].index[IDX_W-1:0];

  // Any legal in-flight op on the requested accumulator stalls the request.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      if (stage_q[i].valid && !stage_q[i].illegal &&
          (stage_q[i].index[IDX_W-1:0] == cur_idx))
        hazard = 1'b1;
    end
  end

  assign io_ready = !hazard;
  assign accept   = io_valid && io_ready;

  // Stage 0 capture, then plain shift through the remaining stages.
  always_comb begin
    stage_d[0]         = '0;
    stage_d[0].valid   = accept;
    stage_d[0].illegal = cur_illegal;
    stage_d[0].op      = cur_illegal ? OP_READ : scie_op_e'(io_insn[14:12]);
    stage_d[0].index   = SCIE_MAX_IDX_W'(cur_idx);
    stage_d[0].rs1     = SCIE_MAX_XLEN'(io_rs1);
    stage_d[0].rs2     = SCIE_MAX_XLEN'(io_rs2);
    for (int i = 1; i < LATENCY; i++)
      stage_d[i] = stage_q[i-1];
  end

  scie_mac_unit #(
    .XLEN (XLEN)
  ) u_mac (
    .op      (stage_q[LATENCY-1].op),
    .acc_in  (acc_q[fin_idx]),
    .rs1     (stage_q[LATENCY-1].rs1[XLEN-1:0]),
    .rs2     (stage_q[LATENCY-1].rs2[XLEN-1:0]),
    .acc_out (mac_out)
  );

  // Final stage: accumulator write-back and registered result.
  always_comb begin
    for (int a = 0; a < NACC; a++)
      acc_d[a] = acc_q[a];
    rd_d       = '0;
    rd_valid_d = stage_q[LATENCY-1].valid;
    illegal_d  = stage_q[LATENCY-1].valid && stage_q[LATENCY-1].illegal;
    if (stage_q[LATENCY-1].valid && !stage_q[LATENCY-1].illegal) begin
      acc_d[fin_idx] = mac_out;
      rd_d           = mac_out;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++)
        stage_q[i] <= '0;
      for (int a = 0; a < NACC; a++)
        acc_q[a] <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      for (int i = 0; i < LATENCY; i++)
        stage_q[i] <= stage_d[i];
      for (int a = 0; a < NACC; a++)
        acc_q[a] <= acc_d[a];
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign io_rd       = rd_q;
  assign io_rd_valid = rd_valid_q;
  assign io_illegal  = illegal_q;

endmodule
